// File: rtl/timer_bank.sv
// timer_bank: bank of CH independent interval timers.
//
// Each channel counts a divider from 0 up to its live `period` value. When
// the divider reaches or passes the period, that clock edge is terminal. A
// terminal edge clears the divider, raises `done` for one cycle, bumps the
// wrapping event counter and sets the sticky interrupt flag. A periodic
// channel keeps running after a terminal edge. A one-shot channel parks in
// EXPIRED until its enable drops.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   [CH]        per-channel enable (low -> IDLE, clears div/count/done)
//   mode       in   [CH]        0 = periodic, 1 = one-shot (sampled at terminal edge)
//   period     in   [CH*DIV_W]  per-channel terminal value, sampled every cycle
//   irq_clr    in   [CH]        per-channel interrupt clear pulse
//   done       out  [CH]        registered one-cycle terminal pulse
//   count      out  [CH*CNT_W]  per-channel wrapping event counter
//   busy       out  [CH]        channel is in RUN
//   irq        out  [CH]        sticky interrupt flags
//   irq_any    out              registered OR of the interrupt flags
//   state_dbg  out  [2*CH]      per-channel FSM state (2 bits per channel)
//
// Handshake: there is no valid/ready traffic here. Every input is a level
// sampled on each rising edge. `irq_clr` acts on any edge where it is high.
// A set from a terminal edge on the same edge overrides the clear.
module timer_bank #(
  parameter int CH    = 4,
  parameter int DIV_W = 32,
  parameter int CNT_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         en,
  input  logic [CH-1:0]         mode,
  input  logic [CH*DIV_W-1:0]   period,
  input  logic [CH-1:0]         irq_clr,
  output logic [CH-1:0]         done,
  output logic [CH*CNT_W-1:0]   count,
  output logic [CH-1:0]         busy,
  output logic [CH-1:0]         irq,
  output logic                  irq_any,
  output logic [2*CH-1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

  state_e           state_q [CH];
  state_e           state_d [CH];
  logic [DIV_W-1:0] div_q   [CH];
  logic [DIV_W-1:0] div_d   [CH];
  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] cnt_d   [CH];
  logic [CH-1:0]    done_q, done_d;
  logic [CH-1:0]    irq_q, irq_d;
  logic             irq_any_q;

  // Next-state logic for every channel.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      div_d[i]   = div_q[i];
      cnt_d[i]   = cnt_q[i];
      done_d[i]  = 1'b0;

      if (!en[i]) begin
        // Disable wins over everything, including a terminal edge.
        state_d[i] = ST_IDLE;
        div_d[i]   = '0;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          // IDLE applies the divider step on the enabling edge itself.
          // Its divider is 0, so only period 0 terminates there.
          ST_IDLE, ST_RUN: begin
            // Using >= lets a lowered period terminate on the next edge
            // instead of waiting for the divider to wrap.
            if (div_q[i] >= period[i*DIV_W +: DIV_W]) begin
              div_d[i]   = '0;
              done_d[i]  = 1'b1;
              cnt_d[i]   = cnt_q[i] + 1'b1;
              state_d[i] = mode[i] ? ST_EXPIRED : ST_RUN;
            end else begin
              div_d[i]   = div_q[i] + 1'b1;
              state_d[i] = ST_RUN;
            end
          end
          ST_EXPIRED: begin
            div_d[i] = '0;
          end
          default: begin
            state_d[i] = ST_IDLE;
            div_d[i]   = '0;
            cnt_d[i]   = '0;
          end
        endcase
      end

      // A set on the same edge as a clear takes priority.
      irq_d[i] = done_d[i] | (irq_q[i] & ~irq_clr[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_IDLE;
        div_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      done_q    <= '0;
      irq_q     <= '0;
      irq_any_q <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        div_q[i]   <= div_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      done_q    <= done_d;
      irq_q     <= irq_d;
      // Built from the next-state flags so it has no extra cycle of lag.
      irq_any_q <= |irq_d;
    end
  end

  always_comb begin
    count     = '0;
    busy      = '0;
    state_dbg = '0;
    for (int i = 0; i < CH; i++) begin
      count[i*CNT_W +: CNT_W] = cnt_q[i];
      busy[i]                 = (state_q[i] == ST_RUN);
      state_dbg[2*i +: 2]     = state_q[i];
    end
  end

  assign done    = done_q;
  assign irq     = irq_q;
  assign irq_any = irq_any_q;

endmodule

// File: tb/tb_timer_bank.sv
module tb_timer_bank;

  localparam int CH    = 4;
  localparam int DIV_W = 32;
  localparam int CNT_W = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [CH-1:0]       en, mode, irq_clr;
  logic [CH*DIV_W-1:0] period;
  logic [CH-1:0]       done, busy, irq;
  logic [CH*CNT_W-1:0] count;
  logic                irq_any;
  logic [2*CH-1:0]     state_dbg;

  timer_bank #(.CH(CH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .period    (period),
    .irq_clr   (irq_clr),
    .done      (done),
    .count     (count),
    .busy      (busy),
    .irq       (irq),
    .irq_any   (irq_any),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_period(input int ch, input logic [31:0] p);
    period[ch*DIV_W +: DIV_W] = p;
  endtask

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(count[ch*CNT_W +: CNT_W]);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pulses;
    int lows;
    logic [31:0] exp_done;

    rst     = 1'b0;
    en      = '0;
    mode    = '0;
    irq_clr = '0;
    period  = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check("rst_done",    32'(done),      0);
    check("rst_count",   32'(count),     0);
    check("rst_busy",    32'(busy),      0);
    check("rst_irq",     32'(irq),       0);
    check("rst_irq_any", 32'(irq_any),   0);
    check("rst_state",   32'(state_dbg), 0);
    rst = 1'b1;

    // Reset mid-run: ch0 period 3 -> terminal at edge 4, then div climbs.
    set_period(0, 3);
    en[0] = 1'b1;
    repeat (7) tick;
    check("midrun_busy",  32'(busy[0]), 1);
    check("midrun_count", cnt_of(0),    1);
    check("midrun_irq",   32'(irq[0]),  1);
    #2 rst = 1'b0;
    #1;
    check("async_done",    32'(done),    0);
    check("async_count",   32'(count),   0);
    check("async_busy",    32'(busy),    0);
    check("async_irq",     32'(irq),     0);
    check("async_irq_any", 32'(irq_any), 0);
    en = '0;
    tick;
    rst = 1'b1;
    repeat (3) tick;
    check("post_rst_count", 32'(count), 0);
    check("post_rst_busy",  32'(busy),  0);
    check("post_rst_irq",   32'(irq),   0);

    // Periodic: ch0 period 4, pulses every 5 cycles.
    set_period(0, 4);
    mode[0] = 1'b0;
    exp_q = '{5, 10, 15, 20, 25, 30};
    en[0] = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick;
      exp_done = 0;
      if (exp_q.size() > 0 && exp_q[0] == 32'(c)) begin
        exp_done = 1;
        void'(exp_q.pop_front());
      end
      check($sformatf("per_done_c%0d", c), 32'(done[0]), exp_done);
      check($sformatf("per_count_c%0d", c), cnt_of(0), 32'(c / 5));
      check($sformatf("per_irq_c%0d", c), 32'(irq[0]), 32'(c >= 5));
      check($sformatf("per_irq_any_c%0d", c), 32'(irq_any), 32'(c >= 5));
    end
    en[0] = 1'b0;
    tick;
    check("per_off_count", cnt_of(0),      0);
    check("per_off_busy",  32'(busy[0]),   0);
    check("per_off_irq",   32'(irq[0]),    1);
    check("per_off_state", 32'(state_dbg[1:0]), 0);
    irq_clr[0] = 1'b1;
    tick;
    irq_clr[0] = 1'b0;
    check("per_clr_irq",     32'(irq[0]),  0);
    check("per_clr_irq_any", 32'(irq_any), 0);

    // One-shot: ch1 period 2 -> single pulse at cycle 3.
    set_period(1, 2);
    mode[1] = 1'b1;
    en[1]   = 1'b1;
    tick;
    check("os_busy_c1", 32'(busy[1]), 1);
    check("os_done_c1", 32'(done[1]), 0);
    tick;
    tick;
    check("os_done_c3",  32'(done[1]),        1);
    check("os_count_c3", cnt_of(1),           1);
    check("os_busy_c3",  32'(busy[1]),        0);
    check("os_state_c3", 32'(state_dbg[3:2]), 2);
    pulses = 0;
    repeat (20) begin
      tick;
      if (done[1]) pulses++;
    end
    check("os_no_repeat", 32'(pulses), 0);
    check("os_count_hold", cnt_of(1), 1);
    en[1] = 1'b0;
    tick;
    check("os_off_count", cnt_of(1),           0);
    check("os_off_state", 32'(state_dbg[3:2]), 0);
    en[1] = 1'b1;
    tick;
    tick;
    check("os_re_done_c2", 32'(done[1]), 0);
    tick;
    check("os_re_done_c3",  32'(done[1]), 1);
    check("os_re_count_c3", cnt_of(1),    1);
    en[1] = 1'b0;
    tick;

    // Period change: ch2 period 100, div reaches 50, then lower to 10.
    set_period(2, 100);
    en[2] = 1'b1;
    pulses = 0;
    repeat (50) begin
      tick;
      if (done[2]) pulses++;
    end
    check("pc_no_early_pulse", 32'(pulses), 0);
    set_period(2, 10);
    tick;
    check("pc_done_now",  32'(done[2]), 1);
    check("pc_count_now", cnt_of(2),    1);
    for (int c = 1; c <= 22; c++) begin
      tick;
      check($sformatf("pc_done_p%0d", c), 32'(done[2]), 32'(c == 11 || c == 22));
    end
    check("pc_count_end", cnt_of(2), 3);
    en[2] = 1'b0;
    tick;

    // Period 0 with counter wrap on ch3.
    set_period(3, 0);
    mode[3] = 1'b0;
    en[3]   = 1'b1;
    lows = 0;
    for (int c = 1; c <= 1025; c++) begin
      tick;
      if (!done[3]) lows++;
      if (c == 1023) check("wrap_count_1023", cnt_of(3), 1023);
      if (c == 1024) check("wrap_count_1024", cnt_of(3), 0);
    end
    check("wrap_done_always", 32'(lows), 0);
    check("wrap_count_end",   cnt_of(3), 1);
    en[3] = 1'b0;
    tick;
    irq_clr = 4'b1110;
    tick;
    irq_clr = '0;
    check("clr_all_irq",     32'(irq),     0);
    check("clr_all_irq_any", 32'(irq_any), 0);

    // Interrupt race on ch0, period 2: terminal edges at 3, 6, 9.
    set_period(0, 2);
    mode[0] = 1'b0;
    en[0]   = 1'b1;
    repeat (3) tick;
    check("race_done_e3", 32'(done[0]), 1);
    check("race_irq_e3",  32'(irq[0]),  1);
    repeat (2) tick;
    irq_clr[0] = 1'b1;
    tick;
    irq_clr[0] = 1'b0;
    check("race_done_e6",    32'(done[0]), 1);
    check("race_irq_e6",     32'(irq[0]),  1);
    check("race_irq_any_e6", 32'(irq_any), 1);
    irq_clr[0] = 1'b1;
    tick;
    irq_clr[0] = 1'b0;
    check("race_done_e7",    32'(done[0]), 0);
    check("race_irq_e7",     32'(irq[0]),  0);
    check("race_irq_any_e7", 32'(irq_any), 0);
    tick;
    // Drop enable so it is sampled low on terminal edge 9.
    en[0] = 1'b0;
    tick;
    check("term_off_done",  32'(done[0]), 0);
    check("term_off_count", cnt_of(0),    0);
    check("term_off_irq",   32'(irq[0]),  0);
    check("term_off_busy",  32'(busy[0]), 0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
